// File: rtl/aer_pkg.sv
// Shared types and default widths for the AER timing blocks.
//   tmr_mode_e      : per-channel timer mode (one-shot / periodic)
//   TMR_*_DEF       : default parameter values for timer_bank
package aer_pkg;

  typedef enum logic {
    TMR_ONESHOT  = 1'b0,
    TMR_PERIODIC = 1'b1
  } tmr_mode_e;

  localparam int unsigned TMR_NUM_CH_DEF  = 4;
  localparam int unsigned TMR_DWIDTH_DEF  = 8;
  localparam int unsigned TMR_PRESC_W_DEF = 8;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counter, one-shot done bit, expiry pulse and level flag.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   tick          common count qualifier (every clk or prescaler wrap)
//   enable, load  count enable, load strobe (load wins)
//   mode          0 = one-shot, 1 = periodic
//   load_value    value written to the counter on load
//   threshold     period in ticks; 0 = always expired, counter frozen
//   flag          combinational level: counter at/after threshold-1
//   expire_p      registered one-cycle expiry pulse
//   expire_nxt_c  combinational next value of expire_p (for the bank OR)
module timer_channel
  import aer_pkg::*;
#(
  parameter int unsigned DWIDTH = TMR_DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              enable,
  input  logic              load,
  input  logic              mode,
  input  logic [DWIDTH-1:0] load_value,
  input  logic [DWIDTH-1:0] threshold,
  output logic              flag,
  output logic              expire_p,
  output logic              expire_nxt_c
);

  logic [DWIDTH-1:0] count;
  logic [DWIDTH-1:0] count_nxt;
  logic              done;
  logic              done_nxt;
  logic              thr_nz;
  logic [DWIDTH-1:0] thr_m1;
  logic              at_thr;
  logic              periodic;

  // threshold-1 is only meaningful when threshold != 0; thr_nz gates every use.
  assign thr_nz   = (threshold != '0);
  assign thr_m1   = threshold - DWIDTH'(1);
  assign at_thr   = (count >= thr_m1);
  assign periodic = (tmr_mode_e'(mode) == TMR_PERIODIC);

  assign flag = !load && (!thr_nz || at_thr);

  // Next-state: load > expiry > increment > hold.
  always_comb begin
    count_nxt    = count;
    done_nxt     = done;
    expire_nxt_c = 1'b0;
    if (load) begin
      count_nxt = load_value;
      done_nxt  = 1'b0;
    end else if (enable && tick && thr_nz) begin
      if (at_thr) begin
        if (periodic) begin
          count_nxt    = '0;
          expire_nxt_c = 1'b1;
        end else if (!done) begin
          expire_nxt_c = 1'b1;
          done_nxt     = 1'b1;
        end
      end else begin
        count_nxt = count + DWIDTH'(1);
      end
    end
  end

  // Channel state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      done     <= 1'b0;
      expire_p <= 1'b0;
    end else begin
      count    <= count_nxt;
      done     <= done_nxt;
      expire_p <= expire_nxt_c;
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH independent programmable timers sharing one tick.
// Optional feature macro: TIMER_PRESCALER_EN (shared free-running prescaler,
// adds the PRESC_W parameter and the prescale port).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   enable        per-channel count enable
//   load          per-channel load strobe (priority over enable)
//   mode          per-channel mode, 0 = one-shot, 1 = periodic
//   load_value    NUM_CH x DWIDTH load values, channel i at [i*DWIDTH +: DWIDTH]
//   threshold     NUM_CH x DWIDTH periods, same packing
//   prescale      tick every prescale+1 clks (TIMER_PRESCALER_EN only)
//   flag          per-channel combinational level flag
//   expire_p      per-channel registered one-cycle expiry pulse
//   any_expire    registered OR of expire_p, aligned with it
module timer_bank
  import aer_pkg::*;
#(
  parameter int unsigned NUM_CH  = TMR_NUM_CH_DEF,
  parameter int unsigned DWIDTH  = TMR_DWIDTH_DEF
`ifdef TIMER_PRESCALER_EN
  ,
  parameter int unsigned PRESC_W = TMR_PRESC_W_DEF
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        enable,
  input  logic [NUM_CH-1:0]        load,
  input  logic [NUM_CH-1:0]        mode,
  input  logic [NUM_CH*DWIDTH-1:0] load_value,
  input  logic [NUM_CH*DWIDTH-1:0] threshold,
`ifdef TIMER_PRESCALER_EN
  input  logic [PRESC_W-1:0]       prescale,
`endif
  output logic [NUM_CH-1:0]        flag,
  output logic [NUM_CH-1:0]        expire_p,
  output logic                     any_expire
);

  logic              tick;
  logic [NUM_CH-1:0] expire_nxt_c;

`ifdef TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_cnt;

  assign tick = (presc_cnt == prescale);

  // Free-running prescaler, counts 0..prescale. If prescale is lowered below
  // the current count it runs through the full range once before realigning.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Per-channel timers.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .DWIDTH (DWIDTH)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .enable       (enable[i]),
      .load         (load[i]),
      .mode         (mode[i]),
      .load_value   (load_value[i*DWIDTH +: DWIDTH]),
      .threshold    (threshold[i*DWIDTH +: DWIDTH]),
      .flag         (flag[i]),
      .expire_p     (expire_p[i]),
      .expire_nxt_c (expire_nxt_c[i])
    );
  end

  // Registered from the same next-state as expire_p so both line up.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_expire <= 1'b0;
    end else begin
      any_expire <= |expire_nxt_c;
    end
  end

endmodule
